// File: rtl/sin_src_nco.sv
// ---------------------------------------------------------------------------
// sin_src_nco
//   Clocked multi-channel sine stimulus source for mixed-signal RNM benches.
//   Each channel owns a PHASE_W-bit phase accumulator (NCO) with a runtime
//   programmable tuning word, phase and amplitude, and drives a real output
//   OFFSET + amp * sin(2*pi*phase / 2^PHASE_W), registered one cycle after
//   the phase it is computed from.
//
// Ports
//   clk           system clock
//   rst_n         synchronous active-low reset
//   en            per-channel run enable
//   cfg_valid     config request
//   cfg_ready     config accepted when cfg_valid & cfg_ready
//   cfg_ch        target channel of the config request
//   cfg_imm       1: apply next cycle, 0: apply at the next phase wrap
//   cfg_ftw       frequency tuning word
//   cfg_phase_ld  1: load cfg_phase into the accumulator when applied
//   cfg_phase     phase value to load
//   cfg_amp       peak amplitude (V)
//   out           sine output per channel (real)
//   wrap          one-cycle pulse after an accumulator carry-out
//   pending       channel holds a deferred, not yet applied update
//
// Build option
//   SIN_SRC_QUANT_EN  when defined, the sine term is quantised to a signed
//                     DAC_BITS code before amplitude scaling and offset.
// ---------------------------------------------------------------------------
module sin_src_nco #(
   parameter int  N_CH     = 2,
   parameter int  PHASE_W  = 16,
   parameter real OFFSET   = 0.0
`ifdef SIN_SRC_QUANT_EN
   ,
   parameter int  DAC_BITS = 12
`endif
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic [N_CH-1:0]                             en,
   input  logic                                        cfg_valid,
   output logic                                        cfg_ready,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  cfg_ch,
   input  logic                                        cfg_imm,
   input  logic [PHASE_W-1:0]                          cfg_ftw,
   input  logic                                        cfg_phase_ld,
   input  logic [PHASE_W-1:0]                          cfg_phase,
   input  real                                         cfg_amp,
   output real                                         out [N_CH],
   output logic [N_CH-1:0]                             wrap,
   output logic [N_CH-1:0]                             pending
);

   localparam real TWO_PI   = 6.283185307179586;
   localparam real PH_SCALE = 2.0 ** PHASE_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PEND
   } ch_state_e;

   // Live channel registers
   logic [PHASE_W-1:0] phase_q [N_CH];
   logic [PHASE_W-1:0] ftw_q   [N_CH];
   real                amp_q   [N_CH];
   real                out_q   [N_CH];
   logic [N_CH-1:0]    wrap_q;
   logic [N_CH-1:0]    pending_q;

   // Shadow registers for deferred updates
   logic [PHASE_W-1:0] sh_ftw_q   [N_CH];
   logic [PHASE_W-1:0] sh_phase_q [N_CH];
   real                sh_amp_q   [N_CH];
   logic [N_CH-1:0]    sh_ld_q;

   ch_state_e          st      [N_CH];
   logic [PHASE_W:0]   inc_sum [N_CH];
   logic [N_CH-1:0]    acc;
   logic               ch_ok;

   // Sine shape term in [-1, 1] for a given accumulator phase.
   function automatic real shape(input logic [PHASE_W-1:0] ph);
      real s;
`ifdef SIN_SRC_QUANT_EN
      int  code;
      int  code_max;
`endif
      s = $sin(TWO_PI * real'(ph) / PH_SCALE);
`ifdef SIN_SRC_QUANT_EN
      code_max = (1 << (DAC_BITS - 1)) - 1;
      code     = int'(s * real'(code_max));
      if (code > code_max)
         code = code_max;
      else if (code < -code_max - 1)
         code = -code_max - 1;
      s = real'(code) / real'(code_max);
`endif
      return s;
   endfunction

   // Channel mode follows the live enable, so an enable drop is seen on the
   // same edge it is sampled.
   always_comb begin
      ch_ok     = (int'(cfg_ch) < N_CH);
      cfg_ready = 1'b1;
      if (ch_ok)
         cfg_ready = !pending_q[cfg_ch];
      for (int unsigned i = 0; i < N_CH; i++) begin
         inc_sum[i] = {1'b0, phase_q[i]} + {1'b0, ftw_q[i]};
         acc[i]     = cfg_valid && cfg_ready && ch_ok && (int'(cfg_ch) == int'(i));
         if (!en[i])
            st[i] = S_IDLE;
         else if (pending_q[i])
            st[i] = S_PEND;
         else
            st[i] = S_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            phase_q[i]    <= '0;
            ftw_q[i]      <= '0;
            amp_q[i]      <= 0.0;
            out_q[i]      <= 0.0;
            sh_ftw_q[i]   <= '0;
            sh_phase_q[i] <= '0;
            sh_amp_q[i]   <= 0.0;
         end
         wrap_q    <= '0;
         pending_q <= '0;
         sh_ld_q   <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            out_q[i]  <= (st[i] == S_IDLE) ? 0.0
                                           : OFFSET + amp_q[i] * shape(phase_q[i]);
            wrap_q[i] <= 1'b0;
            unique case (st[i])
               S_IDLE: begin
                  if (pending_q[i]) begin
                     // enable dropped with an update still shadowed: commit it now
                     ftw_q[i]     <= sh_ftw_q[i];
                     amp_q[i]     <= sh_amp_q[i];
                     if (sh_ld_q[i])
                        phase_q[i] <= sh_phase_q[i];
                     pending_q[i] <= 1'b0;
                  end else if (acc[i]) begin
                     ftw_q[i] <= cfg_ftw;
                     amp_q[i] <= cfg_amp;
                     if (cfg_phase_ld)
                        phase_q[i] <= cfg_phase;
                  end
               end
               S_RUN: begin
                  phase_q[i] <= inc_sum[i][PHASE_W-1:0];
                  wrap_q[i]  <= inc_sum[i][PHASE_W];
                  if (acc[i]) begin
                     if (cfg_imm) begin
                        ftw_q[i] <= cfg_ftw;
                        amp_q[i] <= cfg_amp;
                        if (cfg_phase_ld)
                           phase_q[i] <= cfg_phase;
                     end else begin
                        sh_ftw_q[i]   <= cfg_ftw;
                        sh_phase_q[i] <= cfg_phase;
                        sh_amp_q[i]   <= cfg_amp;
                        sh_ld_q[i]    <= cfg_phase_ld;
                        pending_q[i]  <= 1'b1;
                     end
                  end
               end
               S_PEND: begin
                  phase_q[i] <= inc_sum[i][PHASE_W-1:0];
                  wrap_q[i]  <= inc_sum[i][PHASE_W];
                  // commit on the carry edge so the new frequency starts at a wrap
                  if (inc_sum[i][PHASE_W]) begin
                     ftw_q[i]     <= sh_ftw_q[i];
                     amp_q[i]     <= sh_amp_q[i];
                     if (sh_ld_q[i])
                        phase_q[i] <= sh_phase_q[i];
                     pending_q[i] <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign out     = out_q;
   assign wrap    = wrap_q;
   assign pending = pending_q;

endmodule
